// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU MEM-stage, external-port and data-memory signals of the arbiter
interface dmem_arbiter_if;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        ext_valid;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_ready;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, ext_valid, ext_we, ext_addr, ext_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, ext_ready, ext_rvalid, ext_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, ext_valid, ext_we, ext_addr, ext_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, ext_ready, ext_rvalid, ext_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data memory between the MEM stage and an external port
module dmem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input logic           i_clk,
  input logic           i_rst_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CPU_WAIT, CPU_DONE, EXT_WAIT, EXT_RESP} state_t;
  localparam logic [1:0] LAT_INIT  = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;
  localparam logic [3:0] STARVE_TH = 4'(STARVE_LIM);
  localparam state_t     CPU_NEXT  = (MEM_LAT == 1) ? CPU_DONE : CPU_WAIT;
  localparam state_t     EXT_NEXT  = (MEM_LAT == 1) ? EXT_RESP : EXT_WAIT;
  state_t     r_state, w_next;
  logic [1:0] r_lat, w_lat;
  logic [3:0] r_starve;
  logic       w_cpu_req, w_ext_win;
  assign w_cpu_req = bus.cpu_rd || bus.cpu_wr;
  assign w_ext_win = bus.ext_valid && (r_starve >= STARVE_TH || !w_cpu_req);
  // outputs are combinational from state, so they are gated by reset to stay quiet while it is low
  always_comb begin
    w_next         = r_state;
    w_lat          = r_lat;
    bus.cpu_rdata  = 32'h0;
    bus.cpu_stall  = 1'b0;
    bus.ext_ready  = 1'b0;
    bus.ext_rvalid = 1'b0;
    bus.ext_rdata  = 32'h0;
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = 32'h0;
    bus.mem_wdata  = 32'h0;
    if (i_rst_n)
      case (r_state)
        IDLE:
          if (w_ext_win) begin
            bus.ext_ready = 1'b1;
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.ext_we;
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
            bus.cpu_stall = w_cpu_req;
            w_next        = bus.ext_we ? IDLE : EXT_NEXT;
            w_lat         = LAT_INIT;
          end else if (w_cpu_req) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.cpu_wr;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
            bus.cpu_stall = bus.cpu_rd;
            w_next        = bus.cpu_rd ? CPU_NEXT : IDLE;
            w_lat         = LAT_INIT;
          end
        CPU_WAIT: begin
          bus.cpu_stall = 1'b1;
          w_lat         = r_lat - 2'd1;
          w_next        = (r_lat == 2'd0) ? CPU_DONE : CPU_WAIT;
        end
        CPU_DONE: begin
          bus.cpu_rdata = bus.mem_rdata;
          w_next        = IDLE;
        end
        EXT_WAIT: begin
          bus.cpu_stall = w_cpu_req;
          w_lat         = r_lat - 2'd1;
          w_next        = (r_lat == 2'd0) ? EXT_RESP : EXT_WAIT;
        end
        EXT_RESP: begin
          bus.ext_rvalid = 1'b1;
          bus.ext_rdata  = bus.mem_rdata;
          bus.cpu_stall  = w_cpu_req;
          w_next         = IDLE;
        end
        default: w_next = IDLE;
      endcase
  end
  // a refused external request ages toward priority; acceptance or withdrawal restarts the count
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_lat    <= 2'd0;
      r_starve <= 4'd0;
    end else begin
      r_state  <= w_next;
      r_lat    <= w_lat;
      r_starve <= (bus.ext_valid && !bus.ext_ready) ? ((r_starve == 4'hf) ? r_starve : r_starve + 4'd1) : 4'd0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a MEM_LAT-deep synchronous memory model
module tb_dmem_arbiter;
  localparam int LAT  = 2;
  localparam int SLIM = 4;
  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cpu_q[$];
  logic [31:0] ext_q[$];
  logic [31:0] mem [256];
  logic [31:0] pipe [LAT];
  logic [31:0] exp_v;
  dmem_arbiter_if bus();
  dmem_arbiter #(.MEM_LAT(LAT), .STARVE_LIM(SLIM)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem[bus.mem_addr[9:2]] : 32'h0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[LAT-1];

  task automatic do_load(input logic [31:0] a, output int st, output int en, output logic [31:0] rd,
                         output bit to, output bit rz);
    st = 0; en = 0; rd = 32'h0; to = 1'b1; rz = 1'b1;
    bus.cpu_rd = 1'b1; bus.cpu_addr = a;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      en += int'(bus.mem_en);
      if (!bus.cpu_stall) begin rd = bus.cpu_rdata; to = 1'b0; break; end
      st++;
      if (bus.cpu_rdata !== 32'h0) rz = 1'b0;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0;
  endtask

  task automatic test_reset();
    int st, en; logic [31:0] rd; bit to, rz;
    bus.cpu_rd = 1'b1; bus.cpu_addr = 32'h40;
    bus.ext_valid = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h80; bus.ext_wdata = 32'h5555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.mem_en, bus.cpu_stall, bus.ext_ready} !== 3'b000) begin
        n_err++; $display("FAIL reset_outputs: en/stall/ready=%b want 000", {bus.mem_en, bus.cpu_stall, bus.ext_ready});
      end
    end
    @(posedge clk); #1; rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_en, bus.mem_we, bus.cpu_stall, bus.ext_ready} !== 4'b1010 || bus.mem_addr !== 32'h40) begin
      n_err++; $display("FAIL reset_first_grant: en/we/stall/ready=%b addr=%h want 1010 addr=00000040",
                        {bus.mem_en, bus.mem_we, bus.cpu_stall, bus.ext_ready}, bus.mem_addr);
    end
    @(posedge clk); #1; bus.ext_valid = 1'b0;
    do_load(32'h40, st, en, rd, to, rz);
    n_cmp++;
    if (to || st != LAT - 1) begin n_err++; $display("FAIL reset_first_load: timeout=%0b wait_stalls=%0d want 0/%0d", to, st, LAT - 1); end
  endtask

  task automatic test_stores();
    int st, en; logic [31:0] rd; bit to, rz;
    for (int i = 0; i < 3; i++) begin
      bus.cpu_wr = 1'b1; bus.cpu_addr = 32'(i * 4); bus.cpu_wdata = 32'hA0 + 32'(i * 4);
      @(negedge clk);
      n_cmp++;
      if ({bus.mem_en, bus.mem_we, bus.cpu_stall} !== 3'b110 || bus.mem_addr !== 32'(i * 4) || bus.mem_wdata !== 32'hA0 + 32'(i * 4)) begin
        n_err++; $display("FAIL store_%0d: en/we/stall=%b addr=%h data=%h want 110 addr=%h data=%h", i,
                          {bus.mem_en, bus.mem_we, bus.cpu_stall}, bus.mem_addr, bus.mem_wdata, 32'(i * 4), 32'hA0 + 32'(i * 4));
      end
      @(posedge clk); #1;
    end
    bus.cpu_wr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_en !== 1'b0) begin n_err++; $display("FAIL store_idle: mem_en=%b want 0", bus.mem_en); end
    @(posedge clk); #1;
    cpu_q.push_back(32'hA0);
    do_load(32'h0, st, en, rd, to, rz);
    exp_v = cpu_q.pop_front();
    n_cmp++;
    if (to || rd !== exp_v) begin n_err++; $display("FAIL store_readback: data=%h timeout=%0b want %h", rd, to, exp_v); end
  endtask

  task automatic test_load();
    int st, en; logic [31:0] rd; bit to, rz;
    bus.cpu_wr = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    @(posedge clk); #1; bus.cpu_wr = 1'b0;
    cpu_q.push_back(32'hDEADBEEF);
    do_load(32'h10, st, en, rd, to, rz);
    exp_v = cpu_q.pop_front();
    n_cmp++;
    if (to || st != LAT || en != 1) begin
      n_err++; $display("FAIL load_timing: stalls=%0d mem_en_pulses=%0d timeout=%0b want %0d/1/0", st, en, to, LAT);
    end
    n_cmp++;
    if (rd !== exp_v) begin n_err++; $display("FAIL load_data: cpu_rdata=%h want %h", rd, exp_v); end
    n_cmp++;
    if (!rz) begin n_err++; $display("FAIL load_rdata_quiet: cpu_rdata nonzero during stall, want 0"); end
    cpu_q.push_back(32'hA4);
    cpu_q.push_back(32'hA8);
    for (int i = 1; i <= 2; i++) begin
      do_load(32'(i * 4), st, en, rd, to, rz);
      exp_v = cpu_q.pop_front();
      n_cmp++;
      if (to || st != LAT || rd !== exp_v) begin
        n_err++; $display("FAIL b2b_load_%0d: stalls=%0d data=%h want %0d/%h", i, st, rd, LAT, exp_v);
      end
    end
  endtask

  task automatic test_ext_write();
    int st, en; logic [31:0] rd; bit to, rz;
    bus.ext_valid = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h20; bus.ext_wdata = 32'h12345678;
    @(negedge clk);
    n_cmp++;
    if ({bus.ext_ready, bus.mem_en, bus.mem_we, bus.cpu_stall} !== 4'b1110 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'h12345678) begin
      n_err++; $display("FAIL ext_write_accept: ready/en/we/stall=%b addr=%h data=%h want 1110 00000020 12345678",
                        {bus.ext_ready, bus.mem_en, bus.mem_we, bus.cpu_stall}, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1; bus.ext_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.ext_ready !== 1'b0 || bus.mem_en !== 1'b0) begin
      n_err++; $display("FAIL ext_write_done: ready=%b en=%b want 0 0", bus.ext_ready, bus.mem_en);
    end
    @(posedge clk); #1;
    cpu_q.push_back(32'h12345678);
    do_load(32'h20, st, en, rd, to, rz);
    exp_v = cpu_q.pop_front();
    n_cmp++;
    if (to || rd !== exp_v) begin n_err++; $display("FAIL ext_write_readback: data=%h want %h", rd, exp_v); end
  endtask

  task automatic test_ext_read();
    int n = -1;
    bus.ext_valid = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h10;
    ext_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    n_cmp++;
    if ({bus.ext_ready, bus.mem_en, bus.mem_we, bus.cpu_stall} !== 4'b1100 || bus.mem_addr !== 32'h10) begin
      n_err++; $display("FAIL ext_read_accept: ready/en/we/stall=%b addr=%h want 1100 00000010",
                        {bus.ext_ready, bus.mem_en, bus.mem_we, bus.cpu_stall}, bus.mem_addr);
    end
    @(posedge clk); #1; bus.ext_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.ext_rvalid) begin
        n = k;
        exp_v = ext_q.pop_front();
        n_cmp++;
        if (bus.ext_rdata !== exp_v) begin n_err++; $display("FAIL ext_read_data: ext_rdata=%h want %h", bus.ext_rdata, exp_v); end
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (n != LAT) begin n_err++; $display("FAIL ext_read_latency: rvalid after %0d cycles want %0d", n, LAT); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (bus.ext_rvalid !== 1'b0 || bus.ext_rdata !== 32'h0) begin
      n_err++; $display("FAIL ext_read_pulse: rvalid=%b rdata=%h want 0 00000000", bus.ext_rvalid, bus.ext_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_starve();
    int g = -1, r = -1, re = -1, nd = 0;
    bit stall_ok = 1'b1;
    logic [31:0] ra = 32'h0;
    bus.cpu_rd = 1'b1; bus.cpu_addr = 32'h4;
    bus.ext_valid = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h0;
    ext_q.push_back(32'hA0);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (bus.ext_ready && g < 0) g = k;
      if (g > 0 && r < 0 && !bus.cpu_stall) stall_ok = 1'b0;
      if (bus.ext_rvalid) begin
        r = k;
        exp_v = ext_q.pop_front();
        n_cmp++;
        if (bus.ext_rdata !== exp_v) begin n_err++; $display("FAIL starve_ext_data: ext_rdata=%h want %h", bus.ext_rdata, exp_v); end
      end
      if (r > 0 && re < 0 && bus.mem_en) begin re = k; ra = bus.mem_addr; end
      if (bus.cpu_rd && !bus.cpu_stall) begin
        nd++;
        n_cmp++;
        if (bus.cpu_rdata !== 32'hA4) begin n_err++; $display("FAIL starve_cpu_data: cpu_rdata=%h want 000000a4", bus.cpu_rdata); end
      end
      @(posedge clk); #1;
      if (k == g) bus.ext_valid = 1'b0;
      if (nd == 3) break;
    end
    bus.cpu_rd = 1'b0;
    // loads occupy cycles 1-3 and 4-6; refused count entering cycle k is k-1, first IDLE with >=4 is cycle 7
    n_cmp++;
    if (g != 7) begin n_err++; $display("FAIL starve_grant_cycle: granted at %0d want 7", g); end
    n_cmp++;
    if (r != g + LAT) begin n_err++; $display("FAIL starve_rvalid_cycle: rvalid at %0d want %0d", r, g + LAT); end
    n_cmp++;
    if (!stall_ok) begin n_err++; $display("FAIL starve_stall_hold: cpu_stall dropped during external read, want held"); end
    n_cmp++;
    if (re != r + 1 || ra !== 32'h4 || nd != 3) begin
      n_err++; $display("FAIL starve_resume: issue at %0d addr=%h loads=%0d want %0d 00000004 3", re, ra, nd, r + 1);
    end
  endtask

  task automatic test_reset_mid();
    int st, en; logic [31:0] rd; bit to, rz; bit seen = 1'b0;
    bus.ext_valid = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h8;
    @(negedge clk);
    n_cmp++;
    if (bus.ext_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_accept: ext_ready=%b want 1", bus.ext_ready); end
    @(posedge clk); #1; bus.ext_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_en, bus.cpu_stall, bus.ext_ready, bus.ext_rvalid} !== 4'b0000) begin
      n_err++; $display("FAIL rstmid_outputs: en/stall/ready/rvalid=%b want 0000", {bus.mem_en, bus.cpu_stall, bus.ext_ready, bus.ext_rvalid});
    end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.ext_rvalid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen) begin n_err++; $display("FAIL rstmid_no_rvalid: ext_rvalid seen after reset, want none"); end
    cpu_q.push_back(32'hA8);
    do_load(32'h8, st, en, rd, to, rz);
    exp_v = cpu_q.pop_front();
    n_cmp++;
    if (to || st != LAT || rd !== exp_v) begin
      n_err++; $display("FAIL rstmid_load: stalls=%0d data=%h timeout=%0b want %0d %h 0", st, rd, to, LAT, exp_v);
    end
  endtask

  initial begin
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    bus.ext_valid = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = 32'h0; bus.ext_wdata = 32'h0;
    test_reset();
    test_stores();
    test_load();
    test_ext_write();
    test_ext_read();
    test_starve();
    test_reset_mid();
    n_cmp++;
    if (cpu_q.size() != 0 || ext_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: cpu_q=%0d ext_q=%0d left want 0 0", cpu_q.size(), ext_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequences and shares the single-port synchronous data memory between the pipeline MEM stage and one external requester (loader/DMA/debug port). Issues memory accesses, counts fixed memory read latency, and stalls the pipeline while a CPU load is outstanding or the memory is held by the external port. It sits between the MEM stage's address/write-data outputs and the data memory. It returns load data to the MEM stage in the cycle the MEM/WB register samples it.

## Interface
- MEM_LAT, 1: cycles from issue edge to valid `mem_rdata`; legal range 1..4.
- STARVE_LIM, 4: consecutive cycles `ext_valid` may be refused before the external port gets priority; legal range 1..15.
- clk  in  1  rising-edge clock.
- reset  in  1  **one clock; reset is asynchronous and active-low**. Low clears all state.
- cpu_rd  in  1  MEM stage load request.
- cpu_wr  in  1  MEM stage store request. Never asserted together with `cpu_rd`.
- cpu_addr  in  32  byte address (ALU result).
- cpu_wdata  in  32  store data, already forwarded.
- cpu_rdata  out  32  load data, valid when `cpu_rd && !cpu_stall`.
- cpu_stall  out  1  freezes PC/IF/ID/EX/MEM; MEM/WB loads a bubble.
- ext_valid  in  1  external request; request fields must be held until accepted.
- ext_we  in  1  1 = write, 0 = read.
- ext_addr  in  32  external address.
- ext_wdata  in  32  external write data.
- ext_ready  out  1  accept; transfer occurs on `ext_valid && ext_ready`.
- ext_rvalid  out  1  one-cycle pulse, read data valid.
- ext_rdata  out  32  read data, valid with `ext_rvalid`.
- mem_en, mem_we  out  1 each  memory strobe and write enable. Issue happens when `mem_en` is sampled.
- mem_addr, mem_wdata  out  32 each  memory address and write data; 0 when `mem_en` = 0.
- mem_rdata  in  32  memory read data.

## Operation
- FSM states:
  - IDLE
  - CPU_WAIT
  - CPU_DONE
  - EXT_WAIT
  - EXT_RESP
- Internal counters: 2-bit `lat_cnt`, 4-bit `starve_cnt`.
- Grant rule in IDLE only:
  - The external port wins if `ext_valid` and (`starve_cnt` ≥ STARVE_LIM or no CPU request).
  - Otherwise the CPU wins.
  - No grant is possible in any other state.
- CPU store granted: `mem_en` = `mem_we` = 1 with CPU fields, `cpu_stall` = 0, FSM stays IDLE. One cycle, no stall.
- CPU load granted: `mem_en` = 1 and `mem_we` = 0 with CPU fields.
  - `cpu_stall` = 1.
  - Next state is CPU_WAIT with `lat_cnt` = MEM_LAT−2, or CPU_DONE if MEM_LAT = 1.
- CPU_WAIT: `cpu_stall` = 1, no issue. Decrements `lat_cnt`; moves to CPU_DONE at 0.
- CPU_DONE: `cpu_stall` = 0, `cpu_rdata` = `mem_rdata` (combinational), no issue, next state IDLE.
- External grant: `ext_ready` = 1 and the memory is driven with external fields. `cpu_stall` = `cpu_rd || cpu_wr`. `starve_cnt` clears.
  - Write: stays IDLE.
  - Read: goes to EXT_WAIT (`lat_cnt` = MEM_LAT−2), or to EXT_RESP if MEM_LAT = 1.
- EXT_WAIT: `cpu_stall` = `cpu_rd || cpu_wr`; moves to EXT_RESP at `lat_cnt` 0.
- EXT_RESP: `ext_rvalid` = 1, `ext_rdata` = `mem_rdata`, `cpu_stall` = `cpu_rd || cpu_wr`, next state IDLE.
- `starve_cnt`:
  - Increments, saturating at 15, on every cycle with `ext_valid && !ext_ready`.
  - Clears on external grant or when `ext_valid` = 0.
- `ext_ready` = 0 outside the IDLE grant cycle. `cpu_rdata` and `ext_rdata` are 0 outside their valid cycles.

## Timing
- Reset low (asynchronous): state IDLE, counters 0. All outputs are forced 0 while reset is low, including `mem_en`, `cpu_stall` and `ext_ready`.
- Reset asserted mid-access abandons the access: no `ext_rvalid`, no late `cpu_rdata`. The first grant can occur in the first cycle after reset deasserts.
- CPU load takes MEM_LAT stall cycles, then a done cycle. Total MEM_LAT+1 cycles per load.
- Back-to-back loads: the second issues in the cycle after CPU_DONE.
- CPU store takes 1 cycle. Back-to-back stores issue every cycle.
- External read: `ext_rvalid` appears exactly MEM_LAT cycles after the accept edge. External write takes 1 cycle.
- Simultaneous `ext_valid` and CPU request with `starve_cnt` < STARVE_LIM: the CPU wins and `starve_cnt` increments.
- An external request refused for STARVE_LIM cycles is granted at the next IDLE, even if the CPU requests.
- `ext_valid` dropped before acceptance: the request is withdrawn and `starve_cnt` clears. This is legal.

## Test plan
1. Reset low with `cpu_rd` = 1 and `ext_valid` = 1: `mem_en`, `cpu_stall`, `ext_ready` stay 0. After release, the CPU is granted on the first cycle.
2. MEM_LAT = 2, load at address 0x10 with memory word 0xDEADBEEF:
   - `cpu_stall` = 1 for 2 cycles.
   - Third cycle: `cpu_stall` = 0 and `cpu_rdata` = 0xDEADBEEF.
   - `mem_en` pulses exactly once.
3. Three consecutive stores to 0x0/0x4/0x8: three consecutive `mem_en` = `mem_we` = 1 cycles, `cpu_stall` never asserts.
4. External write of 0x12345678 to 0x20 with the CPU idle: `ext_ready` is 1 in the first cycle. A CPU load of 0x20 issued afterwards returns 0x12345678.
5. STARVE_LIM = 4, continuous CPU loads with `ext_valid` held:
   - External accepted at the first IDLE after `starve_cnt` reaches 4.
   - `cpu_stall` held through the external read.
   - `ext_rvalid` appears MEM_LAT cycles later; the CPU load then resumes.
6. External read outstanding (EXT_WAIT) with reset pulsed low: no `ext_rvalid` ever appears, state returns to IDLE, the next CPU load completes normally.
